// File: rtl/mdio_pkg.sv
// Shared constants, frame slot map and state encoding for the MDIO receiver.
package mdio_pkg;

   localparam logic [1:0] ST_CODE  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int DATA_W  = 16;
   localparam int FRAME_W = 32;

   // Slot indices derived from the field layout ST(2) OP(2) PHYAD REGAD TA(2) DATA.
   localparam int SLOT_OP_END    = 3;
   localparam int SLOT_REGAD_END = SLOT_OP_END + PHYAD_W + REGAD_W;
   localparam int SLOT_TA_END    = SLOT_REGAD_END + 2;
   localparam int SLOT_LAST      = FRAME_W - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WR_DATA,
      S_RD_DATA,
      S_ERR
   } state_t;

   // True when the four leading bits form a legal ST/OP pair.
   function automatic logic header_ok(input logic [3:0] st_op);
      return (st_op[3:2] == ST_CODE) &&
             ((st_op[1:0] == OP_WRITE) || (st_op[1:0] == OP_READ));
   endfunction

endpackage

// File: rtl/receptor_mdio.sv
// PHY-side Clause 22 MDIO receiver: decodes station frames, strobes writes
// into the register bank and serializes read data back to the station.
module receptor_mdio
   import mdio_pkg::*;
(
   input  logic        MDC,
   input  logic        reset,
   input  logic        MDIO_OUT,
   input  logic        MDIO_OE,
   input  logic [0:15] RD_DATA,
   output logic        MDIO_IN,
   output logic [0:4]  ADDR,
   output logic [0:15] WR_DATA,
   output logic        MDIO_DONE,
   output logic        WR_STB
);

   state_t              state, state_d;
   logic [4:0]          cnt, cnt_d;
   logic [3:0]          hdr, hdr_d;
   logic [4:0]          hdr_shift;
   logic [1:0]          op, op_d;
   logic [DATA_W-1:0]   sh, sh_d;
   logic [0:REGAD_W-1]  addr_d;
   logic [0:DATA_W-1]   wr_d;
   logic                in_d, done_d, stb_d;

   // State, counter, shift registers and all outputs are registered here.
   always_ff @(posedge MDC) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      // NOTE: every register, datapath included, is cleared so a mid-frame reset leaves no stale data.
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hdr       <= '0;
         op        <= '0;
         sh        <= '0;
         ADDR      <= '0;
         WR_DATA   <= '0;
         MDIO_IN   <= 1'b0;
         MDIO_DONE <= 1'b0;
         WR_STB    <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         hdr       <= hdr_d;
         op        <= op_d;
         sh        <= sh_d;
         ADDR      <= addr_d;
         WR_DATA   <= wr_d;
         MDIO_IN   <= in_d;
         MDIO_DONE <= done_d;
         WR_STB    <= stb_d;
      end
   end

   // Slot-by-slot frame decoding: next state and next register values.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d   = state;
      cnt_d     = cnt;
      hdr_d     = hdr;
      op_d      = op;
      sh_d      = sh;
      addr_d    = ADDR;
      wr_d      = WR_DATA;
      in_d      = 1'b0;
      done_d    = 1'b0;
      stb_d     = 1'b0;
      // The newest bit sits at position 0; older slots move up.
      hdr_shift = {hdr, MDIO_OUT};

      case (state)
         S_IDLE: begin
            if (MDIO_OE) begin
               hdr_d   = hdr_shift[3:0];
               cnt_d   = 5'd1;
               state_d = S_HDR;
            end
         end

         S_HDR: begin
            if (!MDIO_OE) begin
               state_d = S_ERR;
               cnt_d   = '0;
            end else begin
               hdr_d = hdr_shift[3:0];
               cnt_d = cnt + 5'd1;
               if (cnt == 5'(SLOT_OP_END)) begin
                  op_d = hdr_shift[1:0];
                  if (!header_ok(hdr_shift[3:0])) begin
                     state_d = S_ERR;
                     cnt_d   = '0;
                  end
               end
               if (cnt == 5'(SLOT_REGAD_END)) begin
                  addr_d = hdr_shift;
               end
               if (cnt == 5'(SLOT_TA_END)) begin
                  if (op == OP_WRITE) begin
                     state_d = S_WR_DATA;
                  end else begin
                     // First read bit goes straight out; the rest wait in the shifter.
                     state_d = S_RD_DATA;
                     in_d    = RD_DATA[0];
                     sh_d    = {RD_DATA[1:15], 1'b0};
                  end
               end
            end
         end

         S_WR_DATA: begin
            sh_d  = {sh[DATA_W-2:0], MDIO_OUT};
            cnt_d = cnt + 5'd1;
            if (cnt == 5'(SLOT_LAST)) begin
               wr_d    = {sh[DATA_W-2:0], MDIO_OUT};
               stb_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end

         S_RD_DATA: begin
            if (cnt == 5'(SLOT_LAST)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               in_d  = sh[DATA_W-1];
               sh_d  = {sh[DATA_W-2:0], 1'b0};
               cnt_d = cnt + 5'd1;
            end
         end

         S_ERR: begin
            if (!MDIO_OE) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_receptor_mdio.sv
// Self-checking bench for receptor_mdio: directed frame table, hand-written
// reset sequences and randomized frames against a frame-level model.
module tb_receptor_mdio;

   logic        MDC = 1'b0;
   logic        reset;
   logic        MDIO_OUT;
   logic        MDIO_OE;
   logic [0:15] RD_DATA;
   logic        MDIO_IN;
   logic [0:4]  ADDR;
   logic [0:15] WR_DATA;
   logic        MDIO_DONE;
   logic        WR_STB;

   receptor_mdio dut (
      .MDC       (MDC),
      .reset     (reset),
      .MDIO_OUT  (MDIO_OUT),
      .MDIO_OE   (MDIO_OE),
      .RD_DATA   (RD_DATA),
      .MDIO_IN   (MDIO_IN),
      .ADDR      (ADDR),
      .WR_DATA   (WR_DATA),
      .MDIO_DONE (MDIO_DONE),
      .WR_STB    (WR_STB)
   );

   always #5 MDC = ~MDC;

   int tests = 0;
   int fails = 0;

   // Model of the register-facing outputs that persist between frames.
   logic [4:0]  m_addr;
   logic [15:0] m_wr;

   typedef struct {
      logic [1:0]  st;
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [15:0] data;
      logic [15:0] rd;
      int          drop;   // slot where MDIO_OE falls, 32 = never
      int          gap;    // idle cycles after the frame
      logic        e_done;
      logic        e_stb;
      logic [15:0] e_in;
      logic [4:0]  e_addr;
      logic [15:0] e_wr;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Frame-level reference: a frame completes only with a legal ST/OP and
   // MDIO_OE held through slot 15; REGAD lands once slot 13 is reached.
   function automatic void model(input vec_t v, output logic d, output logic s,
                                 output logic [15:0] iw);
      logic hok;
      hok = (v.st == 2'b01) && (v.op == 2'b01 || v.op == 2'b10);
      d   = hok && (v.drop >= 16);
      s   = d && (v.op == 2'b01);
      iw  = (d && v.op == 2'b10) ? v.rd : 16'h0;
      if (hok && v.drop > 13) m_addr = v.regad;
      if (s) m_wr = v.data;
   endfunction

   task automatic run_frame(input vec_t v, input logic e_done, input logic e_stb,
                            input logic [15:0] e_in, input logic [4:0] e_addr,
                            input logic [15:0] e_wr, input string tag);
      logic [31:0] frame, t_done, t_stb, t_in, x_done, x_stb, x_in;
      logic        quiet;
      int          len;
      frame  = {v.st, v.op, v.phy, v.regad, 2'($urandom), v.data};
      len    = (v.drop < 32) ? v.drop + 1 : 32;
      t_done = '0;
      t_stb  = '0;
      t_in   = '0;
      for (int j = 0; j < len; j++) begin
         if (j == v.drop)             MDIO_OE = 1'b0;
         else if (e_done && j >= 16)  MDIO_OE = 1'($urandom_range(0, 1));
         else                         MDIO_OE = 1'b1;
         MDIO_OUT = (e_done && v.op == 2'b10 && j >= 16) ? 1'($urandom_range(0, 1)) : frame[31-j];
         RD_DATA  = (j <= 15) ? v.rd : 16'($urandom);
         @(posedge MDC);
         #1;
         t_done[j] = MDIO_DONE;
         t_stb[j]  = WR_STB;
         t_in[j]   = MDIO_IN;
      end
      x_done = e_done ? 32'h8000_0000 : 32'h0;
      x_stb  = e_stb  ? 32'h8000_0000 : 32'h0;
      x_in   = '0;
      for (int i = 0; i < 16; i++) x_in[15+i] = e_in[15-i];
      check({tag, "/done_trace"}, t_done, x_done);
      check({tag, "/stb_trace"},  t_stb,  x_stb);
      check({tag, "/mdio_in"},    t_in,   x_in);
      check({tag, "/addr"},       32'(ADDR),    32'(e_addr));
      check({tag, "/wr_data"},    32'(WR_DATA), 32'(e_wr));
      quiet = 1'b1;
      for (int g = 0; g < v.gap; g++) begin
         MDIO_OE  = 1'b0;
         MDIO_OUT = 1'($urandom_range(0, 1));
         @(posedge MDC);
         #1;
         if (MDIO_DONE || WR_STB || MDIO_IN) quiet = 1'b0;
      end
      if (v.gap > 0) check({tag, "/gap_quiet"}, 32'(quiet), 32'd1);
   endtask

   initial begin
      vec_t        v;
      logic        d, s;
      logic [15:0] iw;
      logic [31:0] frame;

      //              st     op     phy       regad     data      rd       drop gap dn stb e_in      addr   wr
      tbl[0] = '{2'b01, 2'b01, 5'b01000, 5'b10100, 16'h5555, 16'h0000, 32, 0, 1, 1, 16'h0000, 5'h14, 16'h5555};
      tbl[1] = '{2'b01, 2'b10, 5'b01000, 5'b10100, 16'h0000, 16'hAAAA, 32, 1, 1, 0, 16'hAAAA, 5'h14, 16'h5555};
      tbl[2] = '{2'b11, 2'b01, 5'b01000, 5'b00001, 16'h0F0F, 16'h0000, 32, 1, 0, 0, 16'h0000, 5'h14, 16'h5555};
      tbl[3] = '{2'b01, 2'b01, 5'b00010, 5'b00011, 16'h1234, 16'h0000, 32, 1, 1, 1, 16'h0000, 5'h03, 16'h1234};
      tbl[4] = '{2'b01, 2'b01, 5'b01000, 5'b11111, 16'hFFFF, 16'h0000, 10, 2, 0, 0, 16'h0000, 5'h03, 16'h1234};
      tbl[5] = '{2'b01, 2'b00, 5'b01000, 5'b00110, 16'h7777, 16'h0000, 32, 1, 0, 0, 16'h0000, 5'h03, 16'h1234};
      tbl[6] = '{2'b01, 2'b01, 5'b00001, 5'b01010, 16'h4321, 16'h0000, 14, 1, 0, 0, 16'h0000, 5'h0A, 16'h1234};
      tbl[7] = '{2'b01, 2'b10, 5'b11111, 5'b11000, 16'h0000, 16'h8001, 32, 0, 1, 0, 16'h8001, 5'h18, 16'h1234};
      tbl[8] = '{2'b01, 2'b01, 5'b10101, 5'b00000, 16'hFFFF, 16'h0000, 32, 1, 1, 1, 16'h0000, 5'h00, 16'hFFFF};

      // Reset held for two edges with the line busy.
      reset    = 1'b0;
      MDIO_OE  = 1'b1;
      MDIO_OUT = 1'b1;
      RD_DATA  = 16'hFFFF;
      repeat (2) @(posedge MDC);
      #1;
      check("reset/addr",    32'(ADDR),    32'h0);
      check("reset/wr_data", 32'(WR_DATA), 32'h0);
      check("reset/strobes", {29'h0, MDIO_IN, MDIO_DONE, WR_STB}, 32'h0);
      reset   = 1'b1;
      MDIO_OE = 1'b0;
      @(posedge MDC);
      #1;

      // Directed frames from the table.
      for (int n = 0; n < 9; n++) begin
         run_frame(tbl[n], tbl[n].e_done, tbl[n].e_stb, tbl[n].e_in,
                   tbl[n].e_addr, tbl[n].e_wr, $sformatf("tbl%0d", n));
      end

      // Reset at slot 20 of a write aborts it and clears the captured fields.
      frame = {2'b01, 2'b01, 5'b00111, 5'b01101, 2'b10, 16'hBEEF};
      for (int j = 0; j < 20; j++) begin
         MDIO_OE  = 1'b1;
         MDIO_OUT = frame[31-j];
         @(posedge MDC);
         #1;
      end
      check("midrst/addr_before", 32'(ADDR), 32'h0D);
      reset    = 1'b0;
      MDIO_OUT = frame[11];
      @(posedge MDC);
      #1;
      check("midrst/addr",    32'(ADDR),    32'h0);
      check("midrst/wr_data", 32'(WR_DATA), 32'h0);
      check("midrst/strobes", {29'h0, MDIO_IN, MDIO_DONE, WR_STB}, 32'h0);
      reset   = 1'b1;
      MDIO_OE = 1'b0;
      @(posedge MDC);
      #1;
      m_addr = 5'h0;
      m_wr   = 16'h0;
      v = '{2'b01, 2'b01, 5'b00111, 5'b01101, 16'hC0DE, 16'h0, 32, 1, 0, 0, 16'h0, 5'h0, 16'h0};
      model(v, d, s, iw);
      run_frame(v, d, s, iw, m_addr, m_wr, "midrst/next");

      // Randomized frames against the model.
      for (int n = 0; n < 40; n++) begin
         v.st    = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b01;
         v.op    = 2'($urandom);
         v.phy   = 5'($urandom);
         v.regad = 5'($urandom);
         v.data  = 16'($urandom);
         v.rd    = 16'($urandom);
         v.drop  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 32;
         model(v, d, s, iw);
         v.gap   = d ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         run_frame(v, d, s, iw, m_addr, m_wr, $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
